// File: rtl/mem_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_io_pkg
//  Purpose  : Shared definitions for the memory/I-O responder: FSM state
//             encoding, I/O window offsets, default I/O base address and a
//             helper for the read-latency wait counter.
//  Ports    : (package, none)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_io_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_WAIT    = 3'd2,
    RD_CAPTURE = 3'd3,
    WR_ISSUE   = 3'd4,
    IO_ACC     = 3'd5,
    RESP       = 3'd6
  } state_t;

  // Word offsets inside the I/O window (address - IO_BASE)
  localparam int unsigned IO_SW   = 0;
  localparam int unsigned IO_LED  = 1;
  localparam int unsigned IO_HEX  = 2;
  localparam int unsigned IO_PERF = 3;

  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;

  // Preload for the RD_WAIT down-counter: RD_WAIT spans lat-1 cycles and
  // exits when the counter reads zero, so it starts at lat-2.
  function automatic logic [1:0] wait_init(input int unsigned lat);
    return (lat >= 2) ? 2'(lat - 2) : 2'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_regs.sv
`default_nettype none
// ============================================================================
//  Module   : io_regs
//  Purpose  : Memory-mapped I/O register file for the responder: two-flop
//             switch synchronizer, LED and hex-display registers, optional
//             access counter, and the combinational read mux.
//  Macro    : MEM_IO_PERF_EN - adds the 16-bit access counter at offset 3
//  Ports    : clk, reset (sync, active-low)
//             sw_in    - raw slide switches (asynchronous)
//             wr_en    - one-cycle write strobe from the responder FSM
//             offset   - word offset into the I/O window
//             wdata    - write data
//             cnt_inc  - (MEM_IO_PERF_EN only) count one completed access
//             rdata    - read data for offset (0 when unmapped)
//             hit      - offset is a mapped register
//             led_out  - LED register
//             hex_out  - hex-display register
//  Revision : 1.0 - initial release
// ============================================================================
module io_regs
  import mem_io_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        sw_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] offset,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_IO_PERF_EN
  input  logic              cnt_inc,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  output logic [9:0]        led_out,
  output logic [15:0]       hex_out
);

  logic [9:0] sw_meta;
  logic [9:0] sw_sync;

  logic sel_sw;
  logic sel_led;
  logic sel_hex;

  assign sel_sw  = (offset == ADDR_W'(IO_SW));
  assign sel_led = (offset == ADDR_W'(IO_LED));
  assign sel_hex = (offset == ADDR_W'(IO_HEX));

  // Switches are mechanical and unrelated to clk; two flops before use.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  // Switch offset is read-only, so no write path for it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      led_out <= '0;
      hex_out <= '0;
    end else if (wr_en) begin
      if (sel_led) led_out <= wdata[9:0];
      if (sel_hex) hex_out <= wdata[15:0];
    end
  end

`ifdef MEM_IO_PERF_EN
  logic        sel_perf;
  logic [15:0] perf_cnt;

  assign sel_perf = (offset == ADDR_W'(IO_PERF));

  // Clear (IO_ACC) and increment (RESP) fall in different cycles of an
  // access, so a clearing write ends up at 1 once its own RESP is counted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_cnt <= '0;
    end else if (wr_en && sel_perf) begin
      perf_cnt <= '0;
    end else if (cnt_inc) begin
      perf_cnt <= perf_cnt + 16'd1;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    hit   = 1'b0;
    if (sel_sw) begin
      rdata = DATA_W'(sw_sync);
      hit   = 1'b1;
    end else if (sel_led) begin
      rdata = DATA_W'(led_out);
      hit   = 1'b1;
    end else if (sel_hex) begin
      rdata = DATA_W'(hex_out);
      hit   = 1'b1;
    end
`ifdef MEM_IO_PERF_EN
    else if (sel_perf) begin
      rdata = DATA_W'(perf_cnt);
      hit   = 1'b1;
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_io_responder
//  Purpose  : Memory-side responder for the multicycle CPU. Accepts one
//             request at a time (valid/ready), routes it to block RAM or the
//             I/O window, sequences the RAM read latency and returns data
//             with a one-cycle resp_ready pulse.
//  Macro    : MEM_IO_PERF_EN - enables the access counter at I/O offset 3
//  Ports    : clk, reset (sync, active-low)
//             req_valid/req_we/req_addr/req_wdata - request from the CPU
//             resp_ready/resp_rdata/resp_err      - completion to the CPU
//             ram_en/ram_we/ram_addr/ram_wdata/ram_rdata - block-RAM port
//             sw_in, led_out, hex_out             - board I/O
//  Revision : 1.0 - initial release
// ============================================================================
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int unsigned       DATA_W  = 16,
  parameter int unsigned       ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT),
  parameter int unsigned       RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [9:0]        sw_in,
  output logic [9:0]        led_out,
  output logic [15:0]       hex_out
);

  localparam logic [1:0] WAIT_INIT = wait_init(RAM_LAT);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        wait_cnt;

  logic [ADDR_W-1:0] io_off;
  logic              io_wr;
  logic [DATA_W-1:0] io_rdata;
  logic              io_hit;

  // The RAM port reflects the latched request for the whole access; only
  // the enables are qualified by state.
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  assign io_off = addr_q - IO_BASE;
  assign io_wr  = (state == IO_ACC) && we_q;

  io_regs #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_io_regs (
    .clk     (clk),
    .reset   (reset),
    .sw_in   (sw_in),
    .wr_en   (io_wr),
    .offset  (io_off),
    .wdata   (wdata_q),
`ifdef MEM_IO_PERF_EN
    .cnt_inc (resp_ready),
`endif
    .rdata   (io_rdata),
    .hit     (io_hit),
    .led_out (led_out),
    .hex_out (hex_out)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      resp_ready <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wait_cnt   <= '0;
    end else begin
      // Pulse-type outputs default low; states below raise them for one cycle.
      resp_ready <= 1'b0;
      resp_err   <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            if (req_addr >= IO_BASE) begin
              state <= IO_ACC;
            end else if (req_we) begin
              state  <= WR_ISSUE;
              ram_en <= 1'b1;
              ram_we <= 1'b1;
            end else begin
              state  <= RD_ISSUE;
              ram_en <= 1'b1;
            end
          end
        end

        RD_ISSUE: begin
          if (RAM_LAT <= 1) begin
            state <= RD_CAPTURE;
          end else begin
            state    <= RD_WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end

        RD_WAIT: begin
          if (wait_cnt == 2'd0) begin
            state <= RD_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end

        RD_CAPTURE: begin
          resp_rdata <= ram_rdata;
          resp_ready <= 1'b1;
          state      <= RESP;
        end

        WR_ISSUE: begin
          resp_ready <= 1'b1;
          state      <= RESP;
        end

        IO_ACC: begin
          // Writes leave the previous read data in place.
          if (!we_q) resp_rdata <= io_rdata;
          resp_err   <= ~io_hit;
          resp_ready <= 1'b1;
          state      <= RESP;
        end

        // One dead cycle guarantees req_valid is not sampled with resp_ready.
        RESP: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the multicycle CPU's load/store/fetch traffic. The CPU controller initiates requests; this block services them.
- Accepts one request at a time on a valid/ready handshake and decodes the address into block-RAM space or a small memory-mapped I/O window.
- Sequences the RAM access with a configurable read latency and returns read data plus a one-cycle ready pulse.
- Sits between the CPU datapath and the board's block RAM, switches, LEDs and hex display.

Parameters:
- DATA_W, 16, data width of requests, RAM and I/O registers.
- ADDR_W, 16, request/RAM address width.
- IO_BASE, 16'hFF00, first address of I/O window; addresses >= IO_BASE are I/O, all lower addresses are RAM.
- RAM_LAT, 1, block-RAM read latency in cycles; legal range 1..3.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- req_valid  in  1  request present; sampled only in IDLE
- req_we  in  1  1 = store, 0 = load/fetch
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- resp_ready  out  1  one-cycle pulse: request complete
- resp_rdata  out  DATA_W  load data; valid from resp_ready, held until next read completes
- resp_err  out  1  pulses with resp_ready when the address is an unmapped I/O address
- ram_en  out  1  block-RAM enable
- ram_we  out  1  block-RAM write enable
- ram_addr  out  ADDR_W  block-RAM address
- ram_wdata  out  DATA_W  block-RAM write data
- ram_rdata  in  DATA_W  block-RAM read data
- sw_in  in  10  asynchronous slide switches
- led_out  out  10  LED register
- hex_out  out  16  hex-display register

Behaviour:
- Reset (synchronous, reset==0): state=IDLE; resp_ready, resp_err, ram_en, ram_we = 0; resp_rdata, led_out, hex_out, latched request = 0. A reset in any state aborts the access; no RAM write occurs unless WR_ISSUE had already completed.
- Request handshake:
  - Acceptance cycle T = IDLE with req_valid=1. Address, write enable and data are latched at T; later changes on the req_* inputs are ignored.
  - req_valid is ignored outside IDLE, including in the RESP cycle. A back-to-back request is accepted no earlier than one cycle after resp_ready.
- States: IDLE, RD_ISSUE, RD_WAIT, RD_CAPTURE, WR_ISSUE, IO_ACC, RESP.
- RAM read:
  - T+1: RD_ISSUE drives ram_en=1 and ram_addr.
  - RD_WAIT lasts RAM_LAT-1 cycles (down-counter).
  - RD_CAPTURE at T+1+RAM_LAT registers ram_rdata into resp_rdata.
  - RESP at T+2+RAM_LAT asserts resp_ready.
- RAM write: T+1 WR_ISSUE drives ram_en=1, ram_we=1, ram_wdata; T+2 RESP. resp_rdata is unchanged.
- I/O access: T+1 IO_ACC, T+2 RESP. Offsets are addr-IO_BASE:
  - 0: switches, read-only; reads return the zero-extended value of a two-flop synchronizer; writes are ignored.
  - 1: LED register, read/write, low 10 bits.
  - 2: hex register, read/write, 16 bits.
  - Other offsets: reads return 0, writes have no effect, resp_err=1 with resp_ready.
- ram_en and ram_we are 0 outside the ISSUE states. ram_addr and ram_wdata hold the latched request.
- Address is the full ADDR_W word address; there is no wrap or alignment logic.

Optional Feature:
- Macro MEM_IO_PERF_EN.
- Defined:
  - Adds a 16-bit access counter at I/O offset 3, incremented by 1 at every resp_ready; it wraps FFFF→0000.
  - A read of offset 3 returns the count before the current access's increment.
  - A write of any value clears it to 0.
  - Reset clears it.
- Undefined: offset 3 is unmapped (reads 0, resp_err pulses).

Decomposition:
- Shared package mem_io_pkg holds:
  - state encoding constants;
  - I/O offset constants (IO_SW=0, IO_LED=1, IO_HEX=2, IO_PERF=3);
  - default IO_BASE.
- One natural sub-module: io_regs (switch synchronizer, LED/hex registers, optional counter, read mux), driven by a write strobe and offset from the FSM.

Test Plan:
- Reset mid-read: accept read of 0x0010, assert reset at T+1 → next cycle state IDLE, ram_en=0, resp_ready never pulses.
- RAM round trip, RAM_LAT=1: write 0xBEEF to 0x0010 → ram_en=ram_we=1 at T+1, resp_ready at T+2. Then read 0x0010 → resp_rdata=0xBEEF with resp_ready at T+3.
- RAM_LAT=3 read of 0x0020 holding 0x1234 → resp_ready exactly at T+5, resp_rdata=0x1234, ram_en high only at T+1.
- I/O: write 0x03FF to 0xFF01 → led_out=0x3FF at T+2. sw_in=0x155 held 3 cycles, then read 0xFF00 → resp_rdata=0x0155. Read 0xFF07 → resp_rdata=0, resp_err=1.
- Handshake: req_valid held high continuously with changing addresses → exactly one acceptance per transaction; the address latched at T is used even if req_addr changes at T+1.
- MEM_IO_PERF_EN defined: 5 accesses, then read 0xFF03 → 0x0005. Write 0xFF03 → next read returns 0x0001 (the write itself is counted after the clear).
